fill_drain_sequencer: RTL and testbench
=======================================

// Module: fill_drain_sequencer
// PURPOSE
//  Water-path sequencer below the wash FSM: accepts FILL/DRAIN commands, drives water_valve and drain_pump,
//  checks water_level_sensor, enforces fill/drain timeouts and pause; raises flow/drainage errors.
//  Valve/pump interlock is guaranteed here, so the top-level FSM only issues commands and watches done/error.
// PARAMETERS
//  LEVEL_W        10   width of level sensor and target
//  TMR_W          12   width of timeout/settle counter
//  FILL_TIMEOUT   600  max active FILL cycles before water_flow_error
//  DRAIN_TIMEOUT  450  max active DRAIN cycles before drainage_error
//  SETTLE_CYCLES  20   settle wait after fill; pump run-on after empty
//  EMPTY_LEVEL    10   level <= this counts as empty
//  LEVEL_TOL      5    allowed level sag after settle
//  MAX_LEVEL      900  overflow threshold (OVERFLOW_GUARD_EN only)
// PORTS
//  clk                 in   1        system clock
//  reset               in   1        asynchronous reset, active-low
//  cmd_valid           in   1        command request
//  cmd_ready           out  1        1 only in IDLE
//  cmd_op              in   1        0=FILL, 1=DRAIN; sampled on accept
//  target_level        in   LEVEL_W  fill target; sampled on accept
//  pause               in   1        level-sensitive hold
//  abort               in   1        cancel current command
//  err_clear           in   1        leave ERROR
//  water_level_sensor  in   LEVEL_W  current water level
//  water_valve         out  1        fill valve drive
//  drain_pump          out  1        drain pump drive
//  busy                out  1        state != IDLE
//  done                out  1        1-cycle pulse on completion
//  water_flow_error    out  1        latched fill timeout/overflow
//  drainage_error      out  1        latched drain timeout
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, counter 0, all outputs 0 except cmd_ready=1; takes effect immediately.
//  - Accept = cmd_valid & cmd_ready at posedge; next cycle in FILL or DRAIN, counter cleared, target latched.
//  - States: IDLE, FILL, SETTLE, DRAIN, RUNON, PAUSED, DONE, ERROR. Moore outputs decoded from registered state:
//    water_valve=1 only in FILL; drain_pump=1 only in DRAIN/RUNON; never both 1.
//  - FILL: level >= target -> SETTLE (counter cleared). Counter reaches FILL_TIMEOUT-1 -> ERROR, water_flow_error=1.
//    target <= level at accept: FILL lasts exactly one cycle.
//  - SETTLE: after SETTLE_CYCLES cycles, level+LEVEL_TOL >= target -> DONE, else back to FILL; counter does not
//    reset on re-entry (top-ups share the FILL_TIMEOUT budget; settle cycles not counted).
//  - DRAIN: level <= EMPTY_LEVEL -> RUNON; counter reaches DRAIN_TIMEOUT-1 -> ERROR, drainage_error=1.
//  - RUNON: pump on for SETTLE_CYCLES cycles, then DONE.
//  - DONE: done=1 one cycle, then IDLE.
//  - PAUSED: entered from FILL/SETTLE/DRAIN/RUNON while pause=1; outputs off, counter frozen, return state held;
//    pause=0 -> return state next cycle.
//  - Priority per cycle: abort > error condition > completion > pause. Abort in any state except IDLE/ERROR -> IDLE
//    next cycle, outputs off, no done. Abort and cmd_valid same cycle in IDLE: command accepted.
//  - ERROR: outputs off, busy=1, cmd_ready=0; exit only via err_clear -> IDLE, clears both error flags.
//  - Level compare unsigned LEVEL_W+1 bits (no wrap on level+LEVEL_TOL). Counter saturates, never wraps.
// CONFIGURATION
//  OVERFLOW_GUARD_EN defined: level >= MAX_LEVEL in FILL/SETTLE/PAUSED -> ERROR, water_flow_error=1, valve off
//    next cycle (beats abort). Undefined: MAX_LEVEL ignored; overflow only ends FILL via target.
// TESTING
//  1 Reset: reset=0 mid-FILL -> valve=0, busy=0, cmd_ready=1 same time, no done.
//  2 FILL target=110, level 0 ->110 at cycle 30 -> valve 1 for cycles 1..30, SETTLE 20 cycles, done pulse, IDLE.
//  3 FILL target=110, level stays 50 -> water_flow_error=1 after 600 FILL cycles, valve=0; err_clear -> IDLE, flag 0.
//  4 DRAIN from level 300, drops to 8 at cycle 40 -> pump 1 through 20-cycle RUNON, then done; valve 0 throughout.
//  5 pause=1 for 50 cycles mid-DRAIN -> pump 0, counter frozen; no drainage_error at 450 wall cycles; resumes DRAIN.
//  6 abort during SETTLE -> IDLE next cycle, no done; (OVERFLOW_GUARD_EN) level=900 in FILL -> ERROR next cycle.

Source files
------------

// File: rtl/fill_drain_sequencer.sv
// Water-path sequencer: runs FILL/DRAIN commands, drives the valve/pump with interlock, enforces timeouts.
// Define OVERFLOW_GUARD_EN to trip water_flow_error when the level reaches MAX_LEVEL during a fill.
module fill_drain_sequencer #(
  parameter int LEVEL_W       = 10,
  parameter int TMR_W         = 12,
  parameter int FILL_TIMEOUT  = 600,
  parameter int DRAIN_TIMEOUT = 450,
  parameter int SETTLE_CYCLES = 20,
  parameter int EMPTY_LEVEL   = 10,
  parameter int LEVEL_TOL     = 5,
  parameter int MAX_LEVEL     = 900
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [LEVEL_W-1:0] target_level,
  input  logic               pause,
  input  logic               abort,
  input  logic               err_clear,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  output logic               water_valve,
  output logic               drain_pump,
  output logic               busy,
  output logic               done,
  output logic               water_flow_error,
  output logic               drainage_error
);

  localparam int LW1 = LEVEL_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RUNON  = 3'd4;
  localparam logic [2:0] S_PAUSED = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]         state, state_nx, ret_state, ret_state_nx;
  logic [TMR_W-1:0]   act_cnt, act_cnt_nx, act_inc;
  logic [TMR_W-1:0]   set_cnt, set_cnt_nx, set_inc;
  logic [LEVEL_W-1:0] target_q, target_nx;
  logic               flow_err_nx, drain_err_nx;
  logic [LW1-1:0]     level_x, target_x;
  logic               level_reached, level_ok, level_empty, overflow;
  logic               fill_expired, drain_expired, settle_end;

  // act_cnt counts active FILL/DRAIN cycles (shared across top-ups); set_cnt times SETTLE and RUNON.
  assign level_x       = {1'b0, water_level_sensor};
  assign target_x      = {1'b0, target_q};
  assign level_reached = level_x >= target_x;
  assign level_ok      = (level_x + LW1'(LEVEL_TOL)) >= target_x;
  assign level_empty   = level_x <= LW1'(EMPTY_LEVEL);
  assign fill_expired  = act_cnt == TMR_W'(FILL_TIMEOUT - 1);
  assign drain_expired = act_cnt == TMR_W'(DRAIN_TIMEOUT - 1);
  assign settle_end    = set_cnt == TMR_W'(SETTLE_CYCLES - 1);
  assign act_inc       = (&act_cnt) ? act_cnt : act_cnt + TMR_W'(1);
  assign set_inc       = (&set_cnt) ? set_cnt : set_cnt + TMR_W'(1);

`ifdef OVERFLOW_GUARD_EN
  assign overflow = (level_x >= LW1'(MAX_LEVEL)) &&
                    (state == S_FILL || state == S_SETTLE || state == S_PAUSED);
`else
  // Without the guard MAX_LEVEL has no effect on behaviour.
  logic unused_max_level;
  assign unused_max_level = ^LW1'(MAX_LEVEL);
  assign overflow         = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_nx     = state;
    ret_state_nx = ret_state;
    act_cnt_nx   = act_cnt;
    set_cnt_nx   = set_cnt;
    target_nx    = target_q;
    flow_err_nx  = water_flow_error;
    drain_err_nx = drainage_error;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nx   = cmd_op ? S_DRAIN : S_FILL;
          act_cnt_nx = '0;
          set_cnt_nx = '0;
          target_nx  = target_level;
        end
      end
      S_FILL: begin
        if (overflow) begin
          state_nx    = S_ERROR;
          flow_err_nx = 1'b1;
        end else if (abort) begin
          state_nx = S_IDLE;
        end else if (fill_expired) begin
          state_nx    = S_ERROR;
          flow_err_nx = 1'b1;
        end else begin
          act_cnt_nx = act_inc;
          if (level_reached) begin
            state_nx   = S_SETTLE;
            set_cnt_nx = '0;
          end else if (pause) begin
            state_nx     = S_PAUSED;
            ret_state_nx = S_FILL;
          end
        end
      end
      S_SETTLE: begin
        if (overflow) begin
          state_nx    = S_ERROR;
          flow_err_nx = 1'b1;
        end else if (abort) begin
          state_nx = S_IDLE;
        end else if (settle_end) begin
          state_nx = level_ok ? S_DONE : S_FILL;
        end else begin
          set_cnt_nx = set_inc;
          if (pause) begin
            state_nx     = S_PAUSED;
            ret_state_nx = S_SETTLE;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (drain_expired) begin
          state_nx     = S_ERROR;
          drain_err_nx = 1'b1;
        end else begin
          act_cnt_nx = act_inc;
          if (level_empty) begin
            state_nx   = S_RUNON;
            set_cnt_nx = '0;
          end else if (pause) begin
            state_nx     = S_PAUSED;
            ret_state_nx = S_DRAIN;
          end
        end
      end
      S_RUNON: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (settle_end) begin
          state_nx = S_DONE;
        end else begin
          set_cnt_nx = set_inc;
          if (pause) begin
            state_nx     = S_PAUSED;
            ret_state_nx = S_RUNON;
          end
        end
      end
      S_PAUSED: begin
        if (overflow) begin
          state_nx    = S_ERROR;
          flow_err_nx = 1'b1;
        end else if (abort) begin
          state_nx = S_IDLE;
        end else if (!pause) begin
          state_nx = ret_state;
        end
      end
      S_DONE: state_nx = S_IDLE;
      S_ERROR: begin
        if (err_clear) begin
          state_nx     = S_IDLE;
          flow_err_nx  = 1'b0;
          drain_err_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      ret_state        <= S_IDLE;
      act_cnt          <= '0;
      set_cnt          <= '0;
      target_q         <= '0;
      water_flow_error <= 1'b0;
      drainage_error   <= 1'b0;
    end else begin
      state            <= state_nx;
      ret_state        <= ret_state_nx;
      act_cnt          <= act_cnt_nx;
      set_cnt          <= set_cnt_nx;
      target_q         <= target_nx;
      water_flow_error <= flow_err_nx;
      drainage_error   <= drain_err_nx;
    end
  end

  // Moore outputs straight from the registered state: valve and pump can never be on together.
  assign cmd_ready   = state == S_IDLE;
  assign busy        = state != S_IDLE;
  assign water_valve = state == S_FILL;
  assign drain_pump  = (state == S_DRAIN) || (state == S_RUNON);
  assign done        = state == S_DONE;

endmodule

// File: tb/tb_fill_drain_sequencer.sv
// Self-checking bench for fill_drain_sequencer: directed scenarios plus randomized fill/drain jobs
// compared against a phase-level model of fill, settle, drain, run-on and pause timing.
module tb_fill_drain_sequencer;

  localparam int FILL_TIMEOUT  = 600;
  localparam int DRAIN_TIMEOUT = 450;
  localparam int SETTLE_CYCLES = 20;
  localparam int LEVEL_TOL     = 5;
  localparam int JOB_LIMIT     = 2000;

  logic       clk, reset, cmd_valid, cmd_ready, cmd_op, pause, abort, err_clear;
  logic [9:0] target_level, water_level_sensor;
  logic       water_valve, drain_pump, busy, done, water_flow_error, drainage_error;

  fill_drain_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .target_level       (target_level),
    .pause              (pause),
    .abort              (abort),
    .err_clear          (err_clear),
    .water_level_sensor (water_level_sensor),
    .water_valve        (water_valve),
    .drain_pump         (drain_pump),
    .busy               (busy),
    .done               (done),
    .water_flow_error   (water_flow_error),
    .drainage_error     (drainage_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Level profile for a job: lv_a before cycle lv_k1, lv_b until lv_k2, lv_c afterwards.
  logic [9:0] lv_a, lv_b, lv_c;
  int         lv_k1, lv_k2;

  int   r_valve, r_pump, r_both, r_done, r_done_at, r_end;
  logic r_ferr, r_derr;
  int   e_valve, e_pump, e_end;
  logic e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] lvl(input int n);
    return (n < lv_k1) ? lv_a : ((n < lv_k2) ? lv_b : lv_c);
  endfunction

  function automatic logic [6:0] outs();
    return {cmd_ready, busy, water_valve, drain_pump, done, water_flow_error, drainage_error};
  endfunction

  task automatic check_outs(input string tag, input logic [6:0] exp);
    check(tag, 32'(outs()), 32'(exp));
  endtask

  // Fill phases: each FILL cycle uses one unit of budget; the budget is exhausted on its last unit.
  function automatic void fill_model(input int tgt, output int valve, output int end_n, output logic err);
    int n, used;
    n = 1; used = 0; valve = 0; end_n = 0; err = 1'b0;
    for (int g = 0; g < 4000; g++) begin
      used++;
      if (used == FILL_TIMEOUT) begin
        valve = used; end_n = n + 1; err = 1'b1;
        return;
      end
      if (int'(lvl(n)) >= tgt) begin
        n += SETTLE_CYCLES;
        if (int'(lvl(n)) + LEVEL_TOL >= tgt) begin
          valve = used; end_n = n + 2;
          return;
        end
        n++;
      end else begin
        n++;
      end
    end
  endfunction

  // Drain with one pause window: paused cycles are ps+1..ps+pl and do not count toward the timeout.
  function automatic void drain_model(input int k, input int ps, input int pl,
                                      output int pump, output int end_n, output logic err);
    int w, active;
    w      = (pl > 0 && k > ps && k <= ps + pl) ? ps + pl + 1 : k;
    active = w - pl;
    if (active >= DRAIN_TIMEOUT) begin
      err   = 1'b1;
      pump  = DRAIN_TIMEOUT;
      end_n = ((pl > 0 && ps < DRAIN_TIMEOUT) ? DRAIN_TIMEOUT + pl : DRAIN_TIMEOUT) + 1;
    end else begin
      err   = 1'b0;
      pump  = active + SETTLE_CYCLES;
      end_n = w + SETTLE_CYCLES + 2;
    end
  endfunction

  // Issue one command and watch it until it returns to idle or reports an error.
  task automatic run_job(input logic op, input logic [9:0] tgt, input int ps, input int pl, input int abort_at);
    int n;
    r_valve = 0; r_pump = 0; r_both = 0; r_done = 0; r_done_at = 0;
    target_level = tgt; cmd_op = op; water_level_sensor = lvl(1);
    pause = 1'b0; abort = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 1;
    while (n <= JOB_LIMIT) begin
      if (water_valve) r_valve++;
      if (drain_pump) r_pump++;
      if (water_valve && drain_pump) r_both++;
      if (done) begin r_done++; r_done_at = n; end
      if (water_flow_error || drainage_error || !busy) break;
      water_level_sensor = lvl(n);
      pause = (pl > 0 && n >= ps && n < ps + pl);
      abort = (n == abort_at);
      step();
      n++;
    end
    pause = 1'b0; abort = 1'b0;
    r_ferr = water_flow_error; r_derr = drainage_error; r_end = n;
  endtask

  task automatic verify_job(input string tag, input int x_valve, input int x_pump, input int x_end,
                            input int x_done, input logic x_ferr, input logic x_derr);
    check({tag, "_valve_cycles"}, r_valve, x_valve);
    check({tag, "_pump_cycles"}, r_pump, x_pump);
    check({tag, "_interlock"}, r_both, 0);
    check({tag, "_end_cycle"}, r_end, x_end);
    check({tag, "_done_pulses"}, r_done, x_done);
    check({tag, "_done_cycle"}, r_done_at, (x_done != 0) ? x_end - 1 : 0);
    check({tag, "_flow_err"}, 32'(r_ferr), 32'(x_ferr));
    check({tag, "_drain_err"}, 32'(r_derr), 32'(x_derr));
  endtask

  task automatic clear_error(input string tag, input logic x_ferr, input logic x_derr);
    check_outs({tag, "_err_hold"}, {5'b01000, x_ferr, x_derr});
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_outs({tag, "_cleared"}, 7'b1000000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, k, ps, pl;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; pause = 1'b0; abort = 1'b0; err_clear = 1'b0;
    target_level = '0; water_level_sensor = '0;
    lv_a = '0; lv_b = '0; lv_c = '0; lv_k1 = 1; lv_k2 = 1 << 20;
    step(); step();
    check_outs("reset_state", 7'b1000000);
    reset = 1'b1;
    step();
    check_outs("idle_after_reset", 7'b1000000);

    // Asynchronous reset in the middle of a fill.
    cmd_valid = 1'b1; cmd_op = 1'b0; target_level = 10'd110; water_level_sensor = 10'd0;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    check_outs("fill_running", 7'b0110000);
    #2 reset = 1'b0;
    #1 check_outs("reset_midfill", 7'b1000000);
    step();
    reset = 1'b1;
    step();
    check_outs("after_midfill_reset", 7'b1000000);

    // Level reaches 110 in FILL cycle 30, settles for 20 cycles, done on cycle 51.
    lv_k1 = 30; lv_a = 10'd0; lv_b = 10'd110; lv_c = 10'd110; lv_k2 = 1 << 20;
    run_job(1'b0, 10'd110, 0, 0, 0);
    verify_job("fill_basic", 30, 0, 52, 1, 1'b0, 1'b0);

    // Level never reaches target: error after 600 FILL cycles.
    lv_k1 = 1; lv_a = 10'd50; lv_b = 10'd50; lv_c = 10'd50;
    run_job(1'b0, 10'd110, 0, 0, 0);
    verify_job("fill_timeout", 600, 0, 601, 0, 1'b1, 1'b0);
    clear_error("fill_timeout", 1'b1, 1'b0);

    // Timeout boundary: target reached on FILL cycle 599 completes, on cycle 600 the timeout wins.
    lv_k1 = 599; lv_a = 10'd0; lv_b = 10'd110; lv_c = 10'd110;
    run_job(1'b0, 10'd110, 0, 0, 0);
    verify_job("fill_599", 599, 0, 621, 1, 1'b0, 1'b0);
    lv_k1 = 600;
    run_job(1'b0, 10'd110, 0, 0, 0);
    verify_job("fill_600", 600, 0, 601, 0, 1'b1, 1'b0);
    clear_error("fill_600", 1'b1, 1'b0);

    // Level sags during settle: top-up shares the original 600-cycle budget.
    lv_k1 = 10; lv_a = 10'd0; lv_b = 10'd110; lv_k2 = 30; lv_c = 10'd100;
    run_job(1'b0, 10'd110, 0, 0, 0);
    verify_job("fill_topup", 600, 0, 621, 0, 1'b1, 1'b0);
    clear_error("fill_topup", 1'b1, 1'b0);

    // Target already met at accept: one FILL cycle.
    lv_k1 = 1; lv_a = 10'd60; lv_b = 10'd60; lv_c = 10'd60; lv_k2 = 1 << 20;
    run_job(1'b0, 10'd50, 0, 0, 0);
    verify_job("fill_met", 1, 0, 23, 1, 1'b0, 1'b0);

    // Drain from 300, empty on cycle 40, 20 run-on cycles.
    lv_k1 = 40; lv_a = 10'd300; lv_b = 10'd8; lv_c = 10'd8; lv_k2 = 40;
    run_job(1'b1, 10'd0, 0, 0, 0);
    verify_job("drain_basic", 0, 60, 62, 1, 1'b0, 1'b0);

    // 50-cycle pause mid-drain: empty at wall cycle 470 is only 420 active cycles.
    lv_k1 = 470; lv_k2 = 470;
    run_job(1'b1, 10'd0, 100, 50, 0);
    verify_job("drain_pause", 0, 440, 492, 1, 1'b0, 1'b0);

    // Drain never empties in time.
    lv_k1 = 460; lv_k2 = 460;
    run_job(1'b1, 10'd0, 0, 0, 0);
    verify_job("drain_timeout", 0, 450, 451, 0, 1'b0, 1'b1);
    clear_error("drain_timeout", 1'b0, 1'b1);

    // Abort during SETTLE: idle next cycle, no done.
    lv_k1 = 5; lv_a = 10'd0; lv_b = 10'd110; lv_c = 10'd110; lv_k2 = 1 << 20;
    run_job(1'b0, 10'd110, 0, 0, 10);
    verify_job("abort_settle", 5, 0, 11, 0, 1'b0, 1'b0);

    // Abort together with cmd_valid in IDLE is accepted; abort in DRAIN returns to IDLE.
    water_level_sensor = 10'd300; cmd_op = 1'b1; cmd_valid = 1'b1; abort = 1'b1;
    step();
    cmd_valid = 1'b0;
    check_outs("abort_accept", 7'b0101000);
    step();
    abort = 1'b0;
    check_outs("abort_drain", 7'b1000000);

`ifdef OVERFLOW_GUARD_EN
    lv_k1 = 5; lv_a = 10'd0; lv_b = 10'd900; lv_c = 10'd900;
    run_job(1'b0, 10'd1000, 0, 0, 0);
    verify_job("overflow", 5, 0, 6, 0, 1'b1, 1'b0);
    clear_error("overflow", 1'b1, 1'b0);
`endif

    // Randomized fills, including sag/top-up profiles; all levels stay below 900.
    for (int i = 0; i < 10; i++) begin
      tgt = 20 + int'($urandom_range(0, 800));
      if ($urandom_range(0, 7) == 0) lv_a = 10'(tgt + int'($urandom_range(0, 50)));
      else lv_a = 10'($urandom_range(0, tgt - 1));
      lv_k1 = int'($urandom_range(1, 700));
      lv_b  = 10'($urandom_range(tgt, 899));
      lv_k2 = lv_k1 + int'($urandom_range(0, 40));
      lv_c  = ($urandom_range(0, 1) == 0) ? lv_b : 10'($urandom_range(0, 899));
      fill_model(tgt, e_valve, e_end, e_err);
      run_job(1'b0, 10'(tgt), 0, 0, 0);
      verify_job($sformatf("rfill%0d", i), e_valve, 0, e_end, e_err ? 0 : 1, e_err, 1'b0);
      if (e_err) clear_error($sformatf("rfill%0d", i), 1'b1, 1'b0);
    end

    // Randomized drains with an optional pause window before the level drops.
    for (int i = 0; i < 10; i++) begin
      ps = int'($urandom_range(5, 100));
      pl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
      k  = int'($urandom_range(ps + 1, 560));
      lv_a = 10'($urandom_range(11, 899));
      lv_b = 10'($urandom_range(0, 10));
      lv_c = lv_b; lv_k1 = k; lv_k2 = k;
      drain_model(k, ps, pl, e_pump, e_end, e_err);
      run_job(1'b1, 10'd0, ps, pl, 0);
      verify_job($sformatf("rdrain%0d", i), 0, e_pump, e_end, e_err ? 0 : 1, 1'b0, e_err);
      if (e_err) clear_error($sformatf("rdrain%0d", i), 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
